// File: rtl/spike_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spike_pkg
// Brief    : Shared widths and window FSM state type for the spike rate
//            decoder and its optional inter-spike-interval timer
//            (ISI_MEASURE_EN).
// Revision : 1.0 - initial release
// ============================================================================
package spike_pkg;

  localparam int SPK_CNT_W = 8;
  localparam int ISI_W     = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spike_rate_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : spike_rate_decoder_if
// Brief    : Valid/ready result channel carrying the per-window spike rate.
//            master = decoder side, slave = consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface spike_rate_decoder_if;
  import spike_pkg::*;

  logic [SPK_CNT_W-1:0] rate_out;
  logic                 rate_valid;
  logic                 rate_ready;

  modport master (
    output rate_out,
    output rate_valid,
    input  rate_ready
  );

  modport slave (
    input  rate_out,
    input  rate_valid,
    output rate_ready
  );

endinterface
`default_nettype wire

// File: rtl/spike_isi_timer.sv
`default_nettype none
// ============================================================================
// Module   : spike_isi_timer
// Brief    : Free-running saturating interval counter. Each rising spike edge
//            reports the cycles since the previous edge. The first edge after
//            reset only arms the measurement. Instantiated only when
//            ISI_MEASURE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module spike_isi_timer
  import spike_pkg::*;
(
  input  wire              clk,
  input  wire              rst,
  input  wire              edge_det,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid
);

  logic [ISI_W-1:0] r_cnt;
  logic [ISI_W-1:0] r_isi_out;
  logic             r_isi_valid;
  logic             r_armed;

  // Interval counter, arm flag and one-cycle result pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_isi_out   <= '0;
      r_isi_valid <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_isi_valid <= 1'b0;
      if (edge_det) begin
        // The reload value of 1 accounts for the edge cycle itself
        r_cnt   <= {{(ISI_W-1){1'b0}}, 1'b1};
        r_armed <= 1'b1;
        if (r_armed) begin
          r_isi_out   <= r_cnt;
          r_isi_valid <= 1'b1;
        end
      end else if (r_cnt != {ISI_W{1'b1}}) begin
        r_cnt <= r_cnt + {{(ISI_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign isi_out   = r_isi_out;
  assign isi_valid = r_isi_valid;

endmodule
`default_nettype wire

// File: rtl/spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_rate_decoder
// Brief    : Counts rising spike edges over back-to-back windows of
//            window_len cycles (0 = 256) and hands each count out on a
//            valid/ready channel. A result that completes while a previous
//            one is still unconsumed is dropped and flagged in drop_err.
//            Define ISI_MEASURE_EN to add inter-spike-interval reporting.
// Revision : 1.0 - initial release
// ============================================================================
module spike_rate_decoder
  import spike_pkg::*;
(
  input  wire                   clk,
  input  wire                   rst,
  input  wire                   spike_in,
  input  wire                   enable,
  input  wire [SPK_CNT_W-1:0]   window_len,
  spike_rate_decoder_if.master  rate_bus,
  output logic                  drop_err,
  output logic [ISI_W-1:0]      isi_out,
  output logic                  isi_valid
);

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_spike_d;
  logic                 w_edge;
  logic [SPK_CNT_W-1:0] r_len;
  logic [SPK_CNT_W-1:0] r_samples;
  logic [SPK_CNT_W-1:0] r_count;
  logic [SPK_CNT_W-1:0] w_last_idx;
  logic [SPK_CNT_W-1:0] w_final_count;
  logic                 w_start;
  logic                 w_sample;
  logic                 w_complete;
  logic [SPK_CNT_W-1:0] r_rate_out;
  logic                 r_rate_valid;
  logic                 r_drop_err;

  assign w_edge = spike_in & ~r_spike_d;

  // Sample index of the last cycle; a latched 0 wraps to 255, giving 256 samples
  assign w_last_idx    = r_len - {{(SPK_CNT_W-1){1'b0}}, 1'b1};
  assign w_final_count = r_count + {{(SPK_CNT_W-1){1'b0}}, w_edge};

  // Edge history runs every cycle regardless of state so boundary edges are seen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spike_d <= 1'b0;
    end else begin
      r_spike_d <= spike_in;
    end
  end

  // Window FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Window FSM next-state and control strobes
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_sample     = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_start      = 1'b1;
          w_state_next = COUNT;
        end
      end
      COUNT: begin
        if (!enable) begin
          w_state_next = IDLE;
        end else begin
          w_sample = 1'b1;
          if (r_samples == w_last_idx) begin
            // Completion relatches immediately so windows run back-to-back
            w_complete = 1'b1;
            w_start    = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Window length latch, sample index and edge accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len     <= '0;
      r_samples <= '0;
      r_count   <= '0;
    end else if (w_start) begin
      r_len     <= window_len;
      r_samples <= '0;
      r_count   <= '0;
    end else if (w_sample) begin
      r_samples <= r_samples + {{(SPK_CNT_W-1){1'b0}}, 1'b1};
      r_count   <= w_final_count;
    end
  end

  // Result register with valid/ready hold and sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rate_out   <= '0;
      r_rate_valid <= 1'b0;
      r_drop_err   <= 1'b0;
    end else if (w_complete) begin
      if (!r_rate_valid || rate_bus.rate_ready) begin
        r_rate_out   <= w_final_count;
        r_rate_valid <= 1'b1;
      end else begin
        r_drop_err <= 1'b1;
      end
    end else if (r_rate_valid && rate_bus.rate_ready) begin
      r_rate_valid <= 1'b0;
    end
  end

  assign rate_bus.rate_out   = r_rate_out;
  assign rate_bus.rate_valid = r_rate_valid;
  assign drop_err            = r_drop_err;

`ifdef ISI_MEASURE_EN
  spike_isi_timer u_isi_timer (
    .clk       (clk),
    .rst       (rst),
    .edge_det  (w_edge),
    .isi_out   (isi_out),
    .isi_valid (isi_valid)
  );
`else
  assign isi_out   = '0;
  assign isi_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_rate_decoder
// Brief    : Self-checking bench for spike_rate_decoder. Expected rates and
//            intervals come from edge counts over the stimulus arrays.
//            ISI checks depend on ISI_MEASURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spike_in = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] window_len = 8'd8;
  logic       drop_err;
  logic [7:0] isi_out;
  logic       isi_valid;

  int total = 0;
  int bad   = 0;
  bit spk [0:4095];

  spike_rate_decoder_if rif ();

  spike_rate_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .spike_in   (spike_in),
    .enable     (enable),
    .window_len (window_len),
    .rate_bus   (rif),
    .drop_err   (drop_err),
    .isi_out    (isi_out),
    .isi_valid  (isi_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // One cycle: inputs change just after the rising edge, outputs read at the falling edge
  task automatic drive(input bit s, input bit en, input bit rdy);
    @(posedge clk);
    #1;
    spike_in       = s;
    enable         = en;
    rif.rate_ready = rdy;
    @(negedge clk);
  endtask

  // Rising edges over stimulus cycles first..last (first >= 1)
  function automatic int model_edges(input int first, input int last);
    int n = 0;
    for (int c = first; c <= last; c++)
      if (spk[c] && !spk[c-1]) n++;
    return n;
  endfunction

  task automatic do_reset();
    spike_in       = 1'b0;
    enable         = 1'b0;
    rif.rate_ready = 1'b1;
    rst            = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs nwin windows with ready held high; start cycle 0 must find the FSM idle
  task automatic run_windows(input int len, input int nwin, input string name);
    int  last_c;
    int  exp_cnt;
    bit  exp_v;
    last_c     = nwin * len + 2;
    window_len = 8'(len);
    for (int c = 0; c < last_c; c++) begin
      drive(spk[c], 1'b1, 1'b1);
      if (c >= 1) begin
        exp_v = (c >= len + 1) && (((c - 1) % len) == 0);
        total++;
        if (rif.rate_valid !== exp_v) begin
          bad++;
          $display("FAIL %s rate_valid cyc %0d: got %0b expected %0b", name, c, rif.rate_valid, exp_v);
        end
        if (exp_v) begin
          exp_cnt = model_edges(c - len, c - 1);
          total++;
          if (rif.rate_out !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL %s rate_out cyc %0d: got %0d expected %0d", name, c, rif.rate_out, exp_cnt);
          end
        end
      end
    end
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    total++;
    if (drop_err !== 1'b0) begin
      bad++;
      $display("FAIL %s drop_err: got %0b expected 0", name, drop_err);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total += 5;
    if (rif.rate_out !== 8'd0) begin bad++; $display("FAIL reset rate_out: got %0d expected 0", rif.rate_out); end
    if (rif.rate_valid !== 1'b0) begin bad++; $display("FAIL reset rate_valid: got %0b expected 0", rif.rate_valid); end
    if (drop_err !== 1'b0) begin bad++; $display("FAIL reset drop_err: got %0b expected 0", drop_err); end
    if (isi_out !== 8'd0) begin bad++; $display("FAIL reset isi_out: got %0d expected 0", isi_out); end
    if (isi_valid !== 1'b0) begin bad++; $display("FAIL reset isi_valid: got %0b expected 0", isi_valid); end
  endtask

  task automatic test_basic();
    bit [7:0] pat;
    do_reset();
    pat = 8'b0001_0101;  // samples 1..8 = 1,0,1,0,1,0,0,0
    spk[0] = 1'b0;
    for (int i = 0; i < 8; i++) spk[i+1] = pat[i];
    spk[9] = 1'b0;
    run_windows(8, 1, "basic");
  endtask

  task automatic test_held();
    do_reset();
    for (int c = 0; c < 10; c++) spk[c] = (c >= 3 && c <= 7);
    run_windows(8, 1, "held");
  endtask

  task automatic test_random();
    int len;
    do_reset();
    repeat (6) begin
      len = $urandom_range(1, 12);
      for (int c = 0; c < 3 * len + 2; c++) spk[c] = 1'($urandom_range(0, 1));
      run_windows(len, 3, "random");
    end
  endtask

  task automatic test_full_window();
    do_reset();
    for (int c = 0; c < 258; c++) spk[c] = c[0];
    run_windows(256, 1, "full256");
  endtask

  task automatic test_backpressure();
    bit [15:0] pat;
    do_reset();
    window_len = 8'd8;
    pat = 16'b0101_0101_0000_0101;  // w1 = 1,0,1,0,0,0,0,0  w2 = 1,0,1,0,1,0,1,0
    drive(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      drive(pat[c-1], 1'b1, 1'b0);
      if (c == 9) begin
        total += 2;
        if (rif.rate_valid !== 1'b1) begin bad++; $display("FAIL bp first valid: got %0b expected 1", rif.rate_valid); end
        if (rif.rate_out !== 8'd2) begin bad++; $display("FAIL bp first rate_out: got %0d expected 2", rif.rate_out); end
      end
      if (c == 16) begin
        total++;
        if (drop_err !== 1'b0) begin bad++; $display("FAIL bp early drop_err: got %0b expected 0", drop_err); end
      end
    end
    drive(1'b0, 1'b0, 1'b1);
    total += 3;
    if (rif.rate_valid !== 1'b1) begin bad++; $display("FAIL bp held valid: got %0b expected 1", rif.rate_valid); end
    if (rif.rate_out !== 8'd2) begin bad++; $display("FAIL bp held rate_out: got %0d expected 2", rif.rate_out); end
    if (drop_err !== 1'b1) begin bad++; $display("FAIL bp drop_err: got %0b expected 1", drop_err); end
    drive(1'b0, 1'b0, 1'b1);
    total += 3;
    if (rif.rate_valid !== 1'b0) begin bad++; $display("FAIL bp release valid: got %0b expected 0", rif.rate_valid); end
    if (rif.rate_out !== 8'd2) begin bad++; $display("FAIL bp release rate_out: got %0d expected 2", rif.rate_out); end
    if (drop_err !== 1'b1) begin bad++; $display("FAIL bp sticky drop_err: got %0b expected 1", drop_err); end
  endtask

  task automatic test_back_to_back();
    bit [7:0] pat;
    do_reset();
    window_len = 8'd4;
    pat = 8'b1011_0001;  // w1 = 1,0,0,0 (1 edge)  w2 = 1,1,0,1 (2 edges)
    drive(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      drive(pat[c-1], 1'b1, (c == 8));
      if (c == 5 || c == 8) begin
        total += 2;
        if (rif.rate_valid !== 1'b1) begin bad++; $display("FAIL b2b w1 valid cyc %0d: got %0b expected 1", c, rif.rate_valid); end
        if (rif.rate_out !== 8'd1) begin bad++; $display("FAIL b2b w1 rate_out cyc %0d: got %0d expected 1", c, rif.rate_out); end
      end
    end
    drive(1'b0, 1'b0, 1'b1);
    total += 3;
    if (rif.rate_valid !== 1'b1) begin bad++; $display("FAIL b2b w2 valid: got %0b expected 1", rif.rate_valid); end
    if (rif.rate_out !== 8'd2) begin bad++; $display("FAIL b2b w2 rate_out: got %0d expected 2", rif.rate_out); end
    if (drop_err !== 1'b0) begin bad++; $display("FAIL b2b drop_err: got %0b expected 0", drop_err); end
    drive(1'b0, 1'b0, 1'b1);
    total++;
    if (rif.rate_valid !== 1'b0) begin bad++; $display("FAIL b2b clear valid: got %0b expected 0", rif.rate_valid); end
  endtask

  task automatic test_abort();
    do_reset();
    window_len = 8'd8;
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, 1'b1);
      total++;
      if (rif.rate_valid !== 1'b0) begin bad++; $display("FAIL abort valid cyc %0d: got %0b expected 0", c, rif.rate_valid); end
    end
    for (int c = 0; c < 12; c++) spk[c] = 1'($urandom_range(0, 1));
    run_windows(5, 2, "after_abort");
  endtask

  task automatic test_reset_mid();
    int exp_cnt;
    do_reset();
    window_len = 8'd8;
    drive(1'b0, 1'b1, 1'b0);
    for (int c = 1; c < 22; c++) spk[c] = c[0];
    spk[0] = 1'b0;
    for (int c = 1; c <= 21; c++) drive(spk[c], 1'b1, 1'b0);
    exp_cnt = model_edges(1, 8);
    total += 3;
    if (rif.rate_valid !== 1'b1) begin bad++; $display("FAIL rstmid pre valid: got %0b expected 1", rif.rate_valid); end
    if (rif.rate_out !== 8'(exp_cnt)) begin bad++; $display("FAIL rstmid pre rate_out: got %0d expected %0d", rif.rate_out, exp_cnt); end
    if (drop_err !== 1'b1) begin bad++; $display("FAIL rstmid pre drop_err: got %0b expected 1", drop_err); end
    #2;
    rst      = 1'b1;
    spike_in = 1'b0;
    enable   = 1'b0;
    #1;
    total += 4;
    if (rif.rate_valid !== 1'b0) begin bad++; $display("FAIL rstmid async valid: got %0b expected 0", rif.rate_valid); end
    if (rif.rate_out !== 8'd0) begin bad++; $display("FAIL rstmid async rate_out: got %0d expected 0", rif.rate_out); end
    if (drop_err !== 1'b0) begin bad++; $display("FAIL rstmid async drop_err: got %0b expected 0", drop_err); end
    if (isi_out !== 8'd0) begin bad++; $display("FAIL rstmid async isi_out: got %0d expected 0", isi_out); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b0, 1'b1);
      total += 2;
      if (rif.rate_valid !== 1'b0) begin bad++; $display("FAIL rstmid stale valid cyc %0d: got %0b expected 0", c, rif.rate_valid); end
      if (rif.rate_out !== 8'd0) begin bad++; $display("FAIL rstmid stale rate_out cyc %0d: got %0d expected 0", c, rif.rate_out); end
    end
    for (int c = 0; c < 10; c++) spk[c] = 1'($urandom_range(0, 1));
    run_windows(4, 2, "after_rst");
  endtask

`ifdef ISI_MEASURE_EN
  // Interval model: edge cycle list, difference to previous edge, clipped at 255
  task automatic run_isi(input int ncyc, input string name);
    int last_edge;
    int e;
    int exp_i;
    bit is_edge;
    bit exp_v;
    last_edge = -1;
    for (int c = 0; c < ncyc; c++) begin
      drive(spk[c], 1'($urandom_range(0, 1)), 1'b1);
      if (c >= 1) begin
        e       = c - 1;
        is_edge = spk[e] && ((e == 0) ? 1'b1 : !spk[e-1]);
        exp_v   = is_edge && (last_edge >= 0);
        total++;
        if (isi_valid !== exp_v) begin
          bad++;
          $display("FAIL %s isi_valid cyc %0d: got %0b expected %0b", name, c, isi_valid, exp_v);
        end
        if (exp_v) begin
          exp_i = (e - last_edge > 255) ? 255 : (e - last_edge);
          total++;
          if (isi_out !== 8'(exp_i)) begin
            bad++;
            $display("FAIL %s isi_out cyc %0d: got %0d expected %0d", name, c, isi_out, exp_i);
          end
        end
        if (is_edge) last_edge = e;
      end
    end
  endtask

  task automatic test_isi();
    do_reset();
    for (int c = 0; c < 320; c++) spk[c] = (c == 3 || c == 10 || c == 310);
    run_isi(316, "isi_directed");
    do_reset();
    for (int c = 0; c < 400; c++) spk[c] = ($urandom_range(0, 9) < 3);
    run_isi(400, "isi_random");
  endtask
`else
  task automatic test_isi();
    do_reset();
    window_len = 8'd5;
    for (int c = 0; c < 40; c++) begin
      drive(1'($urandom_range(0, 1)), 1'b1, 1'b1);
      total += 2;
      if (isi_out !== 8'd0) begin bad++; $display("FAIL isi_off isi_out cyc %0d: got %0d expected 0", c, isi_out); end
      if (isi_valid !== 1'b0) begin bad++; $display("FAIL isi_off isi_valid cyc %0d: got %0b expected 0", c, isi_valid); end
    end
  endtask
`endif

  initial begin
    rif.rate_ready = 1'b1;
    test_reset();
    test_basic();
    test_held();
    test_random();
    test_full_window();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_isi();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, using the ports below.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 spike_in  input  1  spike line from the upstream LSNN neuron (uo_out[0]).
REQ-005 enable  input  1  run request; low aborts the current window.
REQ-006 window_len  input  8  window length in cycles; 0 means 256.
REQ-007 rate_out  output  8  rising-edge count of the last completed window.
REQ-008 rate_valid  output  1  rate_out is holding an unconsumed result.
REQ-009 rate_ready  input  1  consumer accepts rate_out.
REQ-010 drop_err  output  1  sticky flag: a result was lost.
REQ-011 isi_out  output  8  inter-spike interval in cycles.
REQ-012 isi_valid  output  1  one-cycle pulse qualifying isi_out.

Function
REQ-013 SHALL count one spike per rising edge only (spike_in high now, low on the previous cycle); a level held for several cycles counts once.
REQ-014 SHALL keep the edge-detect history register updating every cycle in every state, so an edge that spans a window boundary is seen correctly.
REQ-015 FSM states SHALL be IDLE and COUNT.
REQ-016 IDLE with enable=1 SHALL latch window_len and go to COUNT.
REQ-017 The first sampled cycle SHALL be the cycle after the latch.
REQ-018 COUNT SHALL sample exactly N consecutive cycles, where N = window_len, or 256 when window_len=0.
REQ-019 After the Nth sample, the count SHALL transfer to rate_out with rate_valid=1 on the next cycle.
REQ-020 The next window SHALL start immediately after the transfer (back-to-back), relatching window_len.
REQ-021 The edge counter SHALL be 8 bits; the maximum is 128 edges per 256 cycles, so no saturation logic is needed.
REQ-022 Handshake: rate_valid SHALL stay high and rate_out stable until a cycle with rate_valid and rate_ready both high; rate_valid SHALL clear on the next cycle.
REQ-023 If a window completes while rate_valid is high and rate_ready is low, the new result SHALL be discarded, rate_out SHALL be kept, and drop_err SHALL set.
REQ-024 If a window completes in the same cycle as an accepting handshake, the new result SHALL load and rate_valid SHALL stay high, with no drop.
REQ-025 enable=0 during COUNT SHALL discard the partial count and return to IDLE next cycle; rate_valid and rate_out SHALL be unaffected.
REQ-026 drop_err SHALL clear only on reset.

Reset
REQ-027 rst SHALL asynchronously force the following: state=IDLE, rate_out=0, rate_valid=0, drop_err=0, isi_out=0, isi_valid=0, counters=0, edge history=0, "seen first spike" flag=0.
REQ-028 Reset asserted mid-window SHALL discard all partial state; no result is output.

Configuration
REQ-029 Macro ISI_MEASURE_EN SHALL control the inter-spike-interval logic.
REQ-030 With ISI_MEASURE_EN defined, a free-running 8-bit interval counter SHALL increment every cycle, saturating at 255, independent of enable.
REQ-031 With ISI_MEASURE_EN defined, on each rising edge isi_out SHALL load the counter value with a one-cycle isi_valid pulse, and the counter SHALL reload to 1.
REQ-032 With ISI_MEASURE_EN defined, the first edge after reset SHALL produce no isi_valid; it only arms the interval measurement.
REQ-033 Without ISI_MEASURE_EN, isi_out and isi_valid SHALL be constant 0 and no ISI registers SHALL be synthesized.

Structure
REQ-034 Shared package spike_pkg SHALL hold SPK_CNT_W=8, ISI_W=8 and the FSM state enum (IDLE, COUNT).
REQ-035 The ISI logic SHALL be the sub-module spike_isi_timer, instantiated only under ISI_MEASURE_EN.
REQ-036 The edge detect, window FSM and output register SHALL stay in the top module.

Verification
REQ-037 Basic window: window_len=8, enable=1, rate_ready=1, spike_in=1,0,1,0,1,0,0,0 -> rate_out=3, rate_valid high the cycle after the 8th sample.
REQ-038 Held level: spike_in high for 5 cycles inside an 8-cycle window -> rate_out=1.
REQ-039 Backpressure: rate_ready=0 over two completed windows (results 2 then 4) -> rate_out stays 2, drop_err=1; raising rate_ready -> rate_valid clears next cycle.
REQ-040 Abort and full window:
- enable dropped at sample 4 -> no rate_valid, FSM in IDLE.
- window_len=0 with spike_in toggling every cycle -> rate_out=128 after 256 samples.
REQ-041 ISI (ISI_MEASURE_EN defined): rising edges at cycles 3 and 10 -> no pulse at cycle 3, then isi_out=7 with isi_valid at cycle 10; edges 300 cycles apart -> isi_out=255.
REQ-042 Reset mid-window: rst at sample 5 of 8 -> all outputs 0 immediately, with no stale result after release.
